somador_subtrator_nbits_seq: RTL and testbench
==============================================

# somador_subtrator_nbits_seq

Parametrised, clocked N-bit adder/subtractor with signed-magnitude result and decimal display on DIGITS seven-segment digits plus a sign digit. An operation starts on a `start` pulse. The binary result is converted to BCD by an iterative shift-add-3 (double-dabble) engine, then decoded and held on the displays until the next operation completes. It sits between the board switches/keys and the HEX displays and supersedes the fixed 4-bit combinational adder/subtractor path.

## Interface
- `N`, default 8: operand width in bits, N ≥ 2.
- `DIGITS`, default 3: decimal digits displayed. Must satisfy 10^DIGITS > 2^(N+1)−2; the implementation checks this at elaboration.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `A`  in  N: operand A, unsigned.
- `B`  in  N: operand B, unsigned.
- `SUB`  in  1: 0 = A+B, 1 = A−B. Sampled with `start`.
- `start`  in  1: request. Sampled only in IDLE.
- `busy`  out  1: high from the cycle after an accepted `start` until DONE is left.
- `done`  out  1: one-cycle pulse when the displays update.
- `NEG`  out  1: sign of the last completed result.
- `HEX`  out  7*DIGITS: digit k (k=0 is units) on bits [7k+6:7k]. Bit 7k+i is segment i (a=0 … g=6). Active-low.
- `HEXS`  out  7: sign digit, same encoding. Shows `-` (g low, 7'b0111111 as [6:0]) when NEG=1, otherwise blank (7'b1111111).

## Operation
- FSM states: IDLE → CALC → CONV → DONE → IDLE.
- **IDLE**:
  - `start`=1 latches A, B and SUB into operand registers and moves to CALC.
  - `start` in any other state is ignored, not queued.
- **CALC** (1 cycle):
  - Compute the (N+1)-bit sum A+B, or the two's-complement difference A+~B+1 with a sign-extension bit.
  - Register magnitude |result| (N+1 bits) and sign. Sign is 1 only when SUB=1 and A<B.
  - The magnitude of a negative result is its two's-complement negation. A−A gives magnitude 0 with sign 0 (no negative zero).
  - Clear the BCD register (4*DIGITS bits) and load the bit counter with N+1.
- **CONV** (exactly N+1 cycles):
  - Each cycle, add 3 to every BCD nibble ≥ 5.
  - Then shift {BCD, magnitude} left one bit and decrement the counter.
  - Leave CONV when the counter reaches 0.
- **DONE** (1 cycle):
  - Register the decoded digits into `HEX`, the sign into `NEG` and `HEXS`, and pulse `done`.
  - Leading-zero blanking: digit k>0 is blank if it and every higher digit are 0. Digit 0 always shows a value, so a zero result displays `0`.
- Display and `NEG` registers change only in DONE. They hold their values through IDLE, CALC and CONV.
- Digit encodings ([6:0] = g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble values >9 cannot occur; decode them as blank.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `NEG`=0, `HEX` all ones, `HEXS`=7'b1111111, internal registers cleared.
- Start accepted at edge t. CALC occupies cycle t+1 and CONV cycles t+2 … t+N+2. `done` is high and the new display is visible in cycle t+N+3, which is 11 cycles for N=8.
- `busy` is high in cycles t+1 … t+N+3 inclusive. It is low in the cycle `done` is high only if `done` is registered together with the return to IDLE; the implementation holds `busy`=1 in DONE.
- Back-to-back: `start` can next be accepted in the first IDLE cycle, at t+N+4.
- `rst` asserted in any state returns to IDLE on that edge. It blanks the displays and discards the operation; no `done` is produced.
- Operand inputs may change freely after the accept edge.

## Structure
- Shared package `somador_pkg`:
  - FSM state typedef (IDLE, CALC, CONV, DONE).
  - Segment constants: blank, minus, digits 0–9.
  - Function `digits_needed(N)` for the elaboration check.
- Sub-module `conversor_bin_bcd` #(W, DIGITS): the iterative double-dabble engine with `load`, `busy`/`done` and a BCD output. The top holds the arithmetic, the FSM and the display registers.
- Segment decode is a pure function in the package, applied once per digit in DONE.

## Test plan
All scenarios use N=8, DIGITS=3.
- A=200, B=100, SUB=0, start → `done` exactly 11 cycles later. HEX2..0 shows `3`,`0`,`0`; NEG=0; HEXS blank.
- A=5, B=9, SUB=1 → digit 0 shows `4`, digits 1–2 blank, NEG=1, HEXS=`-`.
- A=255, B=255, SUB=0 → shows `510`. A=0, B=255, SUB=1 → shows `255`, NEG=1. A=B=77, SUB=1 → shows `0`, NEG=0.
- `start` pulsed during CONV with different operands → ignored. The displayed result matches the first operands; exactly one `done`.
- `rst` raised mid-CONV → next cycle IDLE, `busy`=0, HEX all ones, no `done`. A subsequent start completes normally.
- Sweep all 2×256×256 operand/mode combinations against a reference model of sign, magnitude and digit encoding. Check that `busy` and `done` timing is constant across the sweep.

Source files
------------

// File: rtl/somador_pkg.sv
// -----------------------------------------------------------------------------
// somador_pkg
// Shared definitions for the sequential N-bit adder/subtractor with decimal
// seven-segment output.
//   state_t        : top-level FSM states (IDLE, CALC, CONV, DONE)
//   SEG_*          : active-low segment patterns, bit i = segment i (a=0..g=6)
//   seg_decode()   : BCD nibble -> segment pattern (non-decimal nibbles blank)
//   digits_needed(): decimal digits required to show 2^(n+1)-2
// -----------------------------------------------------------------------------
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Smallest d with 10^d > 2^(n+1)-2, the largest magnitude (A+B at full
  // scale). Valid for n up to about 60; the power of ten stops at 10^19.
  function automatic int digits_needed(input int n);
    longint unsigned maxv;
    longint unsigned p;
    int d;
    maxv = (64'd1 << (n + 1)) - 64'd2;
    p = 64'd10;
    d = 1;
    for (int i = 0; i < 19; i++) begin
      if (p <= maxv) begin
        d = d + 1;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd
// Iterative double-dabble (shift-add-3) binary to BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture bin, clear the BCD accumulator, start W shift steps
//   bin      : W-bit unsigned value to convert
//   busy     : conversion in progress
//   done     : high during the final step; bcd already carries the result
//   bcd      : DIGITS packed BCD nibbles, nibble 0 = units
// The bcd output is the accumulator value *after* the current step, so a
// consumer can register the finished result on the same edge that
// completes the last shift instead of waiting one more cycle.
// -----------------------------------------------------------------------------
module conversor_bin_bcd #(
  parameter int W      = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]        bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;

  // Nibbles >= 5 would become >= 10 after doubling; pre-add 3 so the carry
  // lands in the next decimal digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                        : bcd_q[4*gi +: 4];
  end

  assign {bcd_d, bin_d} = {adj, bin_q} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign bcd  = bcd_d;

endmodule

// File: rtl/somador_subtrator_nbits_seq.sv
// -----------------------------------------------------------------------------
// somador_subtrator_nbits_seq
// Clocked N-bit adder/subtractor with signed-magnitude result shown in
// decimal on DIGITS seven-segment digits plus a sign digit.
//   clk, rst : clock, synchronous active-high reset
//   A, B     : unsigned operands, captured when start is accepted
//   SUB      : 0 = A+B, 1 = A-B, captured with start
//   start    : request, only honoured in IDLE
//   busy     : high from the cycle after accept through the DONE cycle
//   done     : one-cycle pulse, coincident with the new display contents
//   NEG      : sign of the last completed result
//   HEX      : digit k on [7k+6:7k], active-low segments a..g, k=0 units
//   HEXS     : sign digit, '-' when NEG=1 else blank
// Latency: accept at edge t, CALC in cycle t+1, CONV for N+1 cycles,
// done/display in cycle t+N+3.
// -----------------------------------------------------------------------------
module somador_subtrator_nbits_seq
  import somador_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          A,
  input  logic [N-1:0]          B,
  input  logic                  SUB,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  NEG,
  output logic [7*DIGITS-1:0]   HEX,
  output logic [6:0]            HEXS
);

  localparam int W = N + 1;

  if (N < 2 || DIGITS < digits_needed(N)) begin : g_param_check
    $error("somador_subtrator_nbits_seq: N must be >= 2 and DIGITS large enough for 2^(N+1)-2");
  end

  state_t              state_q;
  logic [N-1:0]        a_q, b_q;
  logic                sub_q;
  logic                sign_q;
  logic                busy_q;
  logic                done_q;
  logic                neg_q;
  logic [7*DIGITS-1:0] hex_q;
  logic [6:0]          hexs_q;

  // One (N+1)-bit adder serves both modes: A + ~B + 1 in subtract mode.
  // Zero-extending B before inverting makes bit N the borrow/sign bit.
  logic [W-1:0] opb, res, mag;
  logic         res_neg;

  assign opb     = sub_q ? ~{1'b0, b_q} : {1'b0, b_q};
  assign res     = {1'b0, a_q} + opb + {{N{1'b0}}, sub_q};
  // In add mode bit N is a genuine carry, not a sign.
  assign res_neg = sub_q & res[N];
  assign mag     = res_neg ? (~res + W'(1)) : res;

  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;

  conversor_bin_bcd #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == CALC),
    .bin  (mag),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Segment patterns for the finished BCD value. A digit above the units is
  // blanked when it and all higher digits are zero; units always shows.
  logic [7*DIGITS-1:0] seg_next;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    if (gi == 0) begin : g_units
      assign seg_next[6:0] = seg_decode(conv_bcd[3:0]);
    end else begin : g_upper
      assign seg_next[7*gi +: 7] = (|conv_bcd[4*DIGITS-1:4*gi])
                                   ? seg_decode(conv_bcd[4*gi +: 4])
                                   : SEG_BLANK;
    end
  end

  // Display registers load on the edge that enters DONE so the new value
  // is visible in the DONE cycle together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      hex_q   <= '1;
      hexs_q  <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            sub_q   <= SUB;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          sign_q  <= res_neg;
          state_q <= CONV;
        end
        CONV: begin
          if (conv_done) begin
            hex_q   <= seg_next;
            neg_q   <= sign_q;
            hexs_q  <= sign_q ? SEG_MINUS : SEG_BLANK;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (!conv_busy) begin
            // Engine idle without finishing: abandon rather than hang.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign NEG  = neg_q;
  assign HEX  = hex_q;
  assign HEXS = hexs_q;

endmodule

// File: tb/tb_somador_subtrator_nbits_seq.sv
module tb_somador_subtrator_nbits_seq;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_MI = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;

  logic        clk;
  logic        rst;
  logic [7:0]  A, B;
  logic        SUB, start;
  logic        busy, done, NEG;
  logic [20:0] HEX;
  logic [6:0]  HEXS;

  int passed = 0;
  int total  = 0;

  somador_subtrator_nbits_seq #(.N(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .SUB   (SUB),
    .start (start),
    .busy  (busy),
    .done  (done),
    .NEG   (NEG),
    .HEX   (HEX),
    .HEXS  (HEXS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] tseg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference display from integer division, with leading-zero blanking.
  function automatic logic [20:0] model_hex(input int v);
    int d0, d1, d2;
    logic [6:0] h0, h1, h2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = v / 100;
    h0 = tseg(d0);
    h1 = (d2 == 0 && d1 == 0) ? 7'b1111111 : tseg(d1);
    h2 = (d2 == 0) ? 7'b1111111 : tseg(d2);
    return {h2, h1, h0};
  endfunction

  // Issue one operation, scramble the operand inputs after the accept edge,
  // and count negedges until done (done expected on the 11th).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    A = a; B = b; SUB = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = ~a; B = ~b; SUB = ~s;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
    end
    $display("op A=%0d B=%0d SUB=%0d -> HEX=%06h HEXS=%02h NEG=%0d latency=%0d",
             a, b, s, HEX, HEXS, NEG, lat);
  endtask

  task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [20:0] exp_hex, input logic exp_neg);
    int lat;
    logic bok;
    run_op(a, b, s, lat, bok);
    chk({tag, " latency"}, lat, 11);
    chk({tag, " busy"}, bok, 1);
    chk({tag, " HEX"}, HEX, exp_hex);
    chk({tag, " NEG"}, NEG, exp_neg);
    chk({tag, " HEXS"}, HEXS, exp_neg ? S_MI : S_BL);
    @(negedge clk);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " hold HEX"}, HEX, exp_hex);
  endtask

  initial begin
    int dcount, dlat, lat, exp_v;
    logic bok, exp_n;
    logic [7:0] sa, sb;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; SUB = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset NEG", NEG, 0);
    chk("reset HEX", HEX, 21'h1FFFFF);
    chk("reset HEXS", HEXS, S_BL);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset busy", busy, 0);

    // Directed vectors
    op_check("200+100", 8'd200, 8'd100, 1'b0, {S3, S0, S0}, 1'b0);
    op_check("5-9", 8'd5, 8'd9, 1'b1, {S_BL, S_BL, S4}, 1'b1);
    op_check("255+255", 8'd255, 8'd255, 1'b0, {S5, S1, S0}, 1'b0);
    op_check("0-255", 8'd0, 8'd255, 1'b1, {S2, S5, S5}, 1'b1);
    op_check("77-77", 8'd77, 8'd77, 1'b1, {S_BL, S_BL, S0}, 1'b0);
    op_check("100+5", 8'd100, 8'd5, 1'b0, {S1, S0, S5}, 1'b0);

    // start during CONV must be ignored
    @(negedge clk);
    A = 8'd200; B = 8'd100; SUB = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    dlat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) begin
        A = 8'd1; B = 8'd1; SUB = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dcount++;
        if (dlat == 0) dlat = k;
      end
    end
    $display("op A=200 B=100 SUB=0 with ignored start -> HEX=%06h NEG=%0d dones=%0d latency=%0d",
             HEX, NEG, dcount, dlat);
    chk("ignored-start done count", dcount, 1);
    chk("ignored-start latency", dlat, 11);
    chk("ignored-start HEX", HEX, {S3, S0, S0});
    chk("ignored-start NEG", NEG, 0);

    // Reset mid-CONV
    @(negedge clk);
    A = 8'd255; B = 8'd255; SUB = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset HEX", HEX, 21'h1FFFFF);
    chk("midreset HEXS", HEXS, S_BL);
    chk("midreset NEG", NEG, 0);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    $display("op A=255 B=255 SUB=0 aborted by reset -> HEX=%06h dones=%0d", HEX, dcount);
    chk("midreset no done", dcount, 0);
    chk("midreset busy after", busy, 0);
    op_check("after-reset 0-255", 8'd0, 8'd255, 1'b1, {S2, S5, S5}, 1'b1);

    // Strided sweep against the reference model, both modes
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int m = 0; m < 2; m++) begin
          sa = 8'(i * 17);
          sb = 8'((j * 17 + i * 3) % 256);
          if (m == 1) begin
            exp_n = (sa < sb);
            exp_v = exp_n ? int'(sb) - int'(sa) : int'(sa) - int'(sb);
          end else begin
            exp_n = 1'b0;
            exp_v = int'(sa) + int'(sb);
          end
          run_op(sa, sb, m[0], lat, bok);
          chk("sweep latency", lat, 11);
          chk("sweep busy", bok, 1);
          chk("sweep HEX", HEX, model_hex(exp_v));
          chk("sweep NEG", NEG, exp_n);
          chk("sweep HEXS", HEXS, exp_n ? S_MI : S_BL);
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
